// File: rtl/tsc_pkg.sv
// Shared types and constants for the threshold-triggered sampling controller.
package tsc_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEF_DEPTH   = 32;
  localparam int unsigned DEF_POST    = 16;
  localparam int unsigned DEF_PERIOD  = 8;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    IDLE,
    ARST,
    REQ,
    WAIT,
    STORE,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/tsc_ring_buf.sv
// Sample ring buffer: synchronous write, registered read, synchronous clear.
module tsc_ring_buf
  import tsc_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tsc_ctrl.sv
// ADC acquisition controller: request/wait/store loop, threshold trigger,
// post-trigger capture, then oldest-first readout of the frozen ring buffer.
module tsc_ctrl
  import tsc_pkg::*;
#(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned POST    = DEF_POST,
  parameter int unsigned PERIOD  = DEF_PERIOD,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] trd,
  output logic              adc_rst,
  output logic              adc_req,
  input  logic              adc_rdy,
  input  logic [DATA_W-1:0] adc_dat,
  output logic              busy,
  output logic              trig,
  output logic              done,
  output logic              timeout_err,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CNT_MAX = (TIMEOUT > PERIOD) ? TIMEOUT : PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [AW-1:0]     post, post_nx;
  logic [AW-1:0]     wp, wp_nx;
  logic [AW-1:0]     rp, rp_nx;
  logic [AW-1:0]     rcnt, rcnt_nx;
  logic [DATA_W-1:0] sample, sample_nx;
  logic              adc_rst_nx, adc_req_nx, busy_nx, trig_nx, done_nx;
  logic              timeout_err_nx, rd_valid_nx, rd_last_nx;
  logic              clr_c, wr_c, rd_c;
  logic [AW-1:0]     post_inc_c;

  assign post_inc_c = post + AW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      post        <= '0;
      wp          <= '0;
      rp          <= '0;
      rcnt        <= '0;
      sample      <= '0;
      adc_rst     <= 1'b0;
      adc_req     <= 1'b0;
      busy        <= 1'b0;
      trig        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      post        <= post_nx;
      wp          <= wp_nx;
      rp          <= rp_nx;
      rcnt        <= rcnt_nx;
      sample      <= sample_nx;
      adc_rst     <= adc_rst_nx;
      adc_req     <= adc_req_nx;
      busy        <= busy_nx;
      trig        <= trig_nx;
      done        <= done_nx;
      timeout_err <= timeout_err_nx;
      rd_valid    <= rd_valid_nx;
      rd_last     <= rd_last_nx;
    end
  end

  // Next state, counters and the next values of all registered outputs.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    post_nx        = post;
    wp_nx          = wp;
    rp_nx          = rp;
    rcnt_nx        = rcnt;
    sample_nx      = sample;
    trig_nx        = trig;
    timeout_err_nx = timeout_err;
    rd_last_nx     = 1'b0;
    clr_c          = 1'b0;
    wr_c           = 1'b0;
    rd_c           = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx       = ARST;
          trig_nx        = 1'b0;
          timeout_err_nx = 1'b0;
          post_nx        = '0;
          wp_nx          = '0;
          clr_c          = 1'b1;
        end
      end
      ARST: state_nx = REQ;
      REQ: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (adc_rdy) begin
          sample_nx = adc_dat;
          state_nx  = STORE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_err_nx = 1'b1;
          state_nx       = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      STORE: begin
        wr_c     = 1'b1;
        wp_nx    = wp + AW'(1);
        cnt_nx   = '0;
        state_nx = GAP;
        if (!trig && (sample > trd)) begin
          trig_nx = 1'b1;
          post_nx = '0;
        end else if (trig) begin
          post_nx = post_inc_c;
          if (post_inc_c == AW'(POST)) begin
            state_nx = DONE;
            rp_nx    = wp + AW'(1);
            rcnt_nx  = '0;
          end
        end
      end
      GAP: begin
        if (cnt == CNT_W'(PERIOD - 4)) begin
          state_nx = REQ;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        // A new read is accepted only while no strobe is outstanding.
        if (rd_req && !rd_valid) begin
          rd_c    = 1'b1;
          rp_nx   = rp + AW'(1);
          rcnt_nx = rcnt + AW'(1);
          if (rcnt == AW'(DEPTH - 1)) begin
            rd_last_nx = 1'b1;
            state_nx   = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    adc_rst_nx  = (state_nx == ARST);
    adc_req_nx  = (state_nx == REQ);
    busy_nx     = (state_nx inside {ARST, REQ, WAIT, STORE, GAP});
    done_nx     = (state_nx == DONE);
    rd_valid_nx = rd_c;
  end

  tsc_ring_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .wr_en   (wr_c),
    .wr_addr (wp),
    .wr_data (sample),
    .rd_en   (rd_c),
    .rd_addr (rp),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_tsc_ctrl.sv
// Self-checking bench for tsc_ctrl: ADC model, sample-history readout model,
// per-cycle compare process and directed scenarios.
module tb_tsc_ctrl;
  import tsc_pkg::*;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned POST    = 16;
  localparam int unsigned PERIOD  = 8;
  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       adc_rdy = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] trd = 8'h00;
  logic [7:0] adc_dat = 8'h00;
  logic       adc_rst, adc_req, busy, trig, done, timeout_err, rd_valid, rd_last;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  tsc_ctrl #(
    .DEPTH(DEPTH), .POST(POST), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trd(trd),
    .adc_rst(adc_rst), .adc_req(adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat),
    .busy(busy), .trig(trig), .done(done), .timeout_err(timeout_err),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ADC stimulus sequence, restarting at each adc_rst.
  function automatic logic [7:0] seq_val(input int i);
    case (i)
      0: return 8'h8B;
      1: return 8'h8C;
      2: return 8'h99;
      3: return 8'h9B;
      4: return 8'h93;
      5: return 8'h82;
      6: return 8'h97;
      7: return 8'h90;
      8: return 8'h9F;
      9: return 8'hD7;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  // Model: every sample delivered since the last adc_rst, and the trigger index.
  logic [7:0] dq[$];
  int         seq_idx = 0;
  int         trig_idx = -1;
  bit         hold_low = 1'b0;

  function automatic logic [7:0] exp_rd(input int j);
    int k;
    k = dq.size() - DEPTH + j;
    return (k < 0) ? 8'h00 : dq[k];
  endfunction

  initial forever begin
    @(negedge clk);
    if (adc_rst) begin
      adc_rdy  = 1'b0;
      seq_idx  = 0;
      trig_idx = -1;
      dq.delete();
    end else if (adc_req && !hold_low) begin
      adc_dat = seq_val(seq_idx);
      if (trig_idx < 0 && adc_dat > trd) trig_idx = dq.size();
      dq.push_back(adc_dat);
      seq_idx++;
      adc_rdy = 1'b1;
    end
  end

  int         cyc = 0;
  int         last_req = -1;
  int         trig_rise = -1;
  int         trig_at_n = -1;
  int         rd_idx = 0;
  int         rd_cnt = 0;
  int         rst_cnt = 0;
  bit         prev_trig = 1'b0, prev_done = 1'b0, prev_valid = 1'b0;
  logic [7:0] rd_log[DEPTH];
  logic [7:0] run1_log[DEPTH];

  // Compare process, sampling just after each active edge.
  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    if (!rst_n) begin
      last_req   = -1;
      trig_rise  = -1;
      rd_idx     = 0;
      prev_trig  = 1'b0;
      prev_done  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (!busy || adc_rst) last_req = -1;
      if (adc_rst) rst_cnt++;
      if (adc_req) begin
        if (last_req >= 0) chk("req_period", cyc - last_req, PERIOD);
        last_req = cyc;
      end
      if (busy) chk("spurious_trig", (trig && trig_idx < 0), 0);
      if (trig && !prev_trig) begin
        trig_rise = cyc;
        trig_at_n = dq.size();
        chk("trig_sample_pos", dq.size(), trig_idx + 1);
      end
      if (done && !prev_done) begin
        chk("done_samples", dq.size(), trig_idx + 1 + POST);
        chk("trig_to_done", cyc - trig_rise, POST * PERIOD);
        chk("done_busy", busy, 0);
        rd_idx = 0;
      end
      if (rd_valid) begin
        chk("rd_data", rd_data, exp_rd(rd_idx));
        chk("rd_last", rd_last, (rd_idx == DEPTH - 1));
        chk("rd_spacing", prev_valid, 0);
        if (rd_idx < DEPTH) rd_log[rd_idx] = rd_data;
        rd_idx++;
        rd_cnt++;
      end else begin
        chk("rd_last_idle", rd_last, 0);
      end
      prev_trig  = trig;
      prev_done  = done;
      prev_valid = rd_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick(1);
      n++;
    end
    chk("wait_done", done, 1);
  endtask

  task automatic reads_pulsed(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      rd_req = 1'b1;
      tick(1);
      rd_req = 1'b0;
      tick(1);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {adc_rst, adc_req, busy, trig, done, timeout_err, rd_valid, rd_last, rd_data}, 0);
  endtask

  initial begin
    int n;
    int rc;
    bit dropped;

    tick(3);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick(1);

    // Run 1: threshold C0, trigger on the 10th sample.
    trd = 8'hC0;
    pulse_start();
    chk("start_adc_rst", adc_rst, 1);
    chk("start_busy", busy, 1);
    tick(1);
    chk("start_adc_req", {adc_req, adc_rst}, 2'b10);
    wait_done(2000);
    chk("run1_trig", trig, 1);
    chk("run1_trig_n", trig_at_n, 10);
    rc = rst_cnt;
    pulse_start();
    tick(1);
    chk("start_in_done_ignored", {done, busy, 32'(rst_cnt - rc)}, {2'b10, 32'd0});
    rd_cnt = 0;
    reads_pulsed(DEPTH);
    chk("run1_reads", rd_cnt, DEPTH);
    chk("run1_idle", {done, busy, trig}, 3'b001);
    chk("run1_log0", rd_log[0], 8'h00);
    chk("run1_log5", rd_log[5], 8'h00);
    chk("run1_log6", rd_log[6], 8'h8B);
    chk("run1_log15", rd_log[15], 8'hD7);
    chk("run1_log16", rd_log[16], 8'h49);
    chk("run1_log31", rd_log[31], 8'hB2);
    for (int i = 0; i < DEPTH; i++) run1_log[i] = rd_log[i];

    // Run 2: threshold FF never triggers; start and rd_req are ignored.
    trd = 8'hFF;
    pulse_start();
    rc = rst_cnt;
    rd_cnt = 0;
    dropped = 1'b0;
    n = 0;
    while (dq.size() < 105 && n < 2000) begin
      if (!busy || done) dropped = 1'b1;
      if (n % 50 == 10) start = 1'b1;
      if (n % 50 == 30) rd_req = 1'b1;
      tick(1);
      start = 1'b0;
      rd_req = 1'b0;
      n++;
    end
    chk("ff_samples", (dq.size() >= 105), 1);
    chk("ff_busy_held", dropped, 0);
    chk("ff_no_restart", rst_cnt - rc, 0);
    chk("ff_no_reads", rd_cnt, 0);
    chk("ff_flags", {busy, trig, done}, 3'b100);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("ff_reset");
    rst_n = 1'b1;
    tick(1);

    // Run 3: ADC never ready, timeout after 15 WAIT cycles.
    hold_low = 1'b1;
    trd = 8'h8B;
    pulse_start();
    tick(1);
    chk("to_req", adc_req, 1);
    tick(TIMEOUT);
    chk("to_last_wait", {busy, timeout_err}, 2'b10);
    tick(1);
    chk("to_abort", {busy, timeout_err, adc_req}, 3'b010);
    tick(3);
    chk("to_sticky", timeout_err, 1);
    hold_low = 1'b0;
    pulse_start();
    chk("to_cleared", {timeout_err, adc_rst}, 2'b01);

    // Same run continues: strict compare, 8B does not trigger but 8C does.
    wait_done(2000);
    chk("strict_trig_n", trig_at_n, 2);
    rd_cnt = 0;
    rd_req = 1'b1;
    n = 0;
    while (done && n < 200) begin
      tick(1);
      n++;
    end
    rd_req = 1'b0;
    tick(1);
    chk("held_reads", rd_cnt, DEPTH);
    chk("held_cycles", n, 2 * DEPTH - 1);
    chk("held_idle", {done, busy}, 2'b00);
    chk("strict_log13", rd_log[13], 8'h00);
    chk("strict_log14", rd_log[14], 8'h8B);
    chk("strict_log15", rd_log[15], 8'h8C);

    // Run 4: reset mid-GAP, then mid-readout, then a clean rerun of run 1.
    trd = 8'hC0;
    pulse_start();
    n = 0;
    while (!adc_req && n < 20) begin
      tick(1);
      n++;
    end
    chk("gap_req_seen", adc_req, 1);
    tick(3);
    chk("gap_busy", busy, 1);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("gap_reset");
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    wait_done(2000);
    reads_pulsed(10);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("readout_reset");
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    wait_done(2000);
    rd_cnt = 0;
    reads_pulsed(DEPTH);
    chk("rerun_reads", rd_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("rerun_match", rd_log[i], run1_log[i]);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
